// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared pipeline widths, constants and the fetch-queue entry type
//
// Purpose: common definitions for the F/D boundary. No ports.
package cpu_defs;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int IMM_WIDTH   = 16;
  localparam int ENTRY_WIDTH = PC_WIDTH + INSTR_WIDTH;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  // One fetched instruction with its PC; PC sits in the upper half.
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/f_d_ifq_mem.sv
// rtl/f_d_ifq_mem.sv - DEPTH x 64 entry storage, one write port, two combinational read ports
//
// Purpose: register array holding {PC, instruction} entries. Not reset.
// Ports:
//   clk         pipeline clock
//   i_we        write enable
//   i_waddr     write address
//   i_wdata     write data
//   i_raddr0    head read address        -> o_rdata0
//   i_raddr1    head+1 read address      -> o_rdata1
module ifq_mem
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [ENTRY_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr0,
  output logic [ENTRY_WIDTH-1:0] o_rdata0,
  input  logic [AW-1:0]          i_raddr1,
  output logic [ENTRY_WIDTH-1:0] o_rdata1
);

  logic [ENTRY_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/f_d_ifq.sv
// rtl/f_d_ifq.sv - instruction fetch queue between F and D with redirect flush and delay-slot keep
//
// Purpose: circular buffer of DEPTH {PC, instr} pairs; head is presented to D.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   F_valid/F_PC/F_Instr    fetched instruction from F
//   F_ready                 queue accepts a push this cycle
//   D_pop                   D consumes the head entry
//   D_flush, D_keep_slot    redirect flush, optionally retaining one delay slot
//   D_valid/D_PC/D_Instr    head entry (zeros when empty)
//   D_Imm                   D_Instr[15:0] for the immediate extender
//   count                   occupancy
module f_d_ifq
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   F_valid,
  input  logic [PC_WIDTH-1:0]    F_PC,
  input  logic [INSTR_WIDTH-1:0] F_Instr,
  output logic                   F_ready,
  input  logic                   D_pop,
  input  logic                   D_flush,
  input  logic                   D_keep_slot,
  output logic                   D_valid,
  output logic [PC_WIDTH-1:0]    D_PC,
  output logic [INSTR_WIDTH-1:0] D_Instr,
  output logic [IMM_WIDTH-1:0]   D_Imm,
  output logic [CW-1:0]          count
);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  ifq_entry_t    w_wdata;
  ifq_entry_t    w_head;
  ifq_entry_t    w_head1;
  ifq_entry_t    w_f_entry;
  logic          w_push;
  logic          w_pop;
  logic          w_has_rest;

  assign w_f_entry = '{pc: F_PC, instr: F_Instr};

  assign D_valid = (r_count != '0);
  assign F_ready = (r_count < CW'(DEPTH)) || D_pop;
  assign w_push  = F_valid && F_ready;
  assign w_pop   = D_pop && D_valid;

  // True when an entry survives the pop of this cycle.
  assign w_has_rest = (r_count > CW'(w_pop));

  ifq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr0 (r_rd_ptr),
    .o_rdata0 (w_head),
    .i_raddr1 (r_rd_ptr + AW'(1)),
    .o_rdata1 (w_head1)
  );

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    w_we         = 1'b0;
    w_waddr      = r_wr_ptr;
    w_wdata      = w_f_entry;
    if (D_flush) begin
      if (D_keep_slot && (w_has_rest || F_valid)) begin
        // The retained slot is rewritten into the current head location so
        // the queue restarts as a single entry at rd_ptr, wherever the slot
        // came from (head, head+1 when popping, or this cycle's fetch).
        w_we         = 1'b1;
        w_waddr      = r_rd_ptr;
        w_wdata      = !w_has_rest ? w_f_entry : (w_pop ? w_head1 : w_head);
        w_wr_ptr_nxt = r_rd_ptr + AW'(1);
        w_count_nxt  = CW'(1);
      end else begin
        w_rd_ptr_nxt = r_wr_ptr;
        w_count_nxt  = '0;
      end
    end else begin
      w_we = w_push;
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      end
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign D_PC    = D_valid ? w_head.pc : '0;
  assign D_Instr = D_valid ? w_head.instr : NOP_INSTR;
  assign D_Imm   = D_Instr[IMM_WIDTH-1:0];
  assign count   = r_count;

endmodule

// File: tb/tb_f_d_ifq.sv
// tb/tb_f_d_ifq.sv - directed self-checking bench for f_d_ifq
module tb_f_d_ifq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        F_valid;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_ready;
  logic        D_pop;
  logic        D_flush;
  logic        D_keep_slot;
  logic        D_valid;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [15:0] D_Imm;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  f_d_ifq #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .F_valid     (F_valid),
    .F_PC        (F_PC),
    .F_Instr     (F_Instr),
    .F_ready     (F_ready),
    .D_pop       (D_pop),
    .D_flush     (D_flush),
    .D_keep_slot (D_keep_slot),
    .D_valid     (D_valid),
    .D_PC        (D_PC),
    .D_Instr     (D_Instr),
    .D_Imm       (D_Imm),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Instruction word tagged with its PC: upper half fixed opcode, imm = PC[15:0] ^ 0x0F0F.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'h8C22, pc[15:0] ^ 16'h0F0F};
  endfunction

  // Inputs change only right after a falling edge; one rising edge per call.
  task automatic cycle(input logic fv, input logic [31:0] pc, input logic pop,
                       input logic flush, input logic keep);
    F_valid = fv; F_PC = pc; F_Instr = instr_of(pc);
    D_pop = pop; D_flush = flush; D_keep_slot = keep;
    @(posedge clk);
    @(negedge clk);
    F_valid = 1'b0; D_pop = 1'b0; D_flush = 1'b0; D_keep_slot = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    F_valid = 0; F_PC = 0; F_Instr = 0; D_pop = 0; D_flush = 0; D_keep_slot = 0;
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({D_valid, D_PC, D_Instr, D_Imm, count, F_ready} !== {1'b0, 32'h0, 32'h0, 16'h0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b pc=%h i=%h imm=%h cnt=%0d rdy=%b, want 0/0/0/0/0/1",
               D_valid, D_PC, D_Instr, D_Imm, count, F_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++;
    if (count !== 3'd0 || D_valid !== 1'b0 || F_ready !== 1'b1) begin
      bad++;
      $display("FAIL pop_empty: got cnt=%0d v=%b rdy=%b, want 0/0/1", count, D_valid, F_ready);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h3000 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== 3'd4 || F_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full: got cnt=%0d rdy=%b, want 4/0", count, F_ready);
    end
    cycle(1'b1, 32'h3010, 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== 3'd4 || D_PC !== 32'h3000 || D_Instr !== 32'h8C22_3F0F || D_Imm !== 16'h3F0F) begin
      bad++;
      $display("FAIL full_reject_head: got cnt=%0d pc=%h i=%h imm=%h, want 4/3000/8c223f0f/3f0f",
               count, D_PC, D_Instr, D_Imm);
    end
  endtask

  task automatic test_push_pop_full();
    F_valid = 1'b1; D_pop = 1'b1;
    #1;
    total++;
    if (F_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_ready_with_pop: got %b, want 1", F_ready);
    end
    cycle(1'b1, 32'h3010, 1'b1, 1'b0, 1'b0);
    total++;
    if (count !== 3'd4 || D_PC !== 32'h3004) begin
      bad++;
      $display("FAIL push_pop_full: got cnt=%0d pc=%h, want 4/3004", count, D_PC);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      total++;
      if (D_PC !== 32'h3008 + 32'(4 * k) || D_Instr !== instr_of(32'h3008 + 32'(4 * k)) ||
          count !== 3'(3 - k)) begin
        bad++;
        $display("FAIL wrap_order_%0d: got pc=%h i=%h cnt=%0d, want pc=%h cnt=%0d",
                 k, D_PC, D_Instr, count, 32'h3008 + 32'(4 * k), 3 - k);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++;
    if (D_valid !== 1'b0 || D_PC !== 32'h0 || D_Instr !== 32'h0 || count !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty: got v=%b pc=%h i=%h cnt=%0d, want 0/0/0/0", D_valid, D_PC, D_Instr, count);
    end
  endtask

  task automatic test_flush_pop_slot();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h3000 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h300C, 1'b1, 1'b1, 1'b1);
    total++;
    if (count !== 3'd1 || D_PC !== 32'h3004 || D_Instr !== 32'h8C22_3F0B) begin
      bad++;
      $display("FAIL flush_pop_keep: got cnt=%0d pc=%h i=%h, want 1/3004/8c223f0b", count, D_PC, D_Instr);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++;
    if (D_valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL flush_discard_rest: got v=%b cnt=%0d, want 0/0", D_valid, count);
    end
    // Keep without pop retains the head itself.
    cycle(1'b1, 32'h4000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h4004, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h4008, 1'b0, 1'b1, 1'b1);
    total++;
    if (count !== 3'd1 || D_PC !== 32'h4000) begin
      bad++;
      $display("FAIL flush_keep_nopop: got cnt=%0d pc=%h, want 1/4000", count, D_PC);
    end
  endtask

  task automatic test_flush_push_slot();
    do_reset();
    cycle(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3004, 1'b1, 1'b1, 1'b1);
    total++;
    if (count !== 3'd1 || D_PC !== 32'h3004 || D_Imm !== 16'h3F0B) begin
      bad++;
      $display("FAIL flush_keep_push: got cnt=%0d pc=%h imm=%h, want 1/3004/3f0b", count, D_PC, D_Imm);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3004, 1'b1, 1'b1, 1'b0);
    total++;
    if (count !== 3'd0 || D_valid !== 1'b0 || D_PC !== 32'h0) begin
      bad++;
      $display("FAIL flush_nokeep: got cnt=%0d v=%b pc=%h, want 0/0/0", count, D_valid, D_PC);
    end
    cycle(1'b1, 32'h3008, 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== 3'd1 || D_PC !== 32'h3008) begin
      bad++;
      $display("FAIL after_flush_push: got cnt=%0d pc=%h, want 1/3008", count, D_PC);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h5000 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || D_valid !== 1'b0 || D_PC !== 32'h0 || D_Instr !== 32'h0 || F_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got cnt=%0d v=%b pc=%h i=%h rdy=%b, want 0/0/0/0/1",
               count, D_valid, D_PC, D_Instr, F_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    F_valid = 1'b1; F_PC = 32'h3020; F_Instr = instr_of(32'h3020);
    #1;
    total++;
    if (D_valid !== 1'b0) begin
      bad++;
      $display("FAIL no_bypass: got v=%b, want 0", D_valid);
    end
    cycle(1'b1, 32'h3020, 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== 3'd1 || D_PC !== 32'h3020 || D_Instr !== 32'h8C22_3F2F) begin
      bad++;
      $display("FAIL post_reset_push: got cnt=%0d pc=%h i=%h, want 1/3020/8c223f2f", count, D_PC, D_Instr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_push_pop_full();
    test_flush_pop_slot();
    test_flush_push_slot();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/f_d_ifq.md
# f_d_ifq

Instruction fetch queue between the F stage (instruction memory read) and the D stage (decode, GRF read, immediate extension). It buffers up to DEPTH fetched {PC, instruction} pairs, so F keeps fetching while D is stalled. It presents the head entry to D with the immediate field pre-split for the extender. It also handles branch/jump redirect flushes, including preserving the delay-slot instruction.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  pipeline clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- F_valid  in  1  F presents a fetched instruction this cycle
- F_PC  in  32  PC of fetched instruction
- F_Instr  in  32  fetched instruction word
- F_ready  out  1  queue accepts a push this cycle
- D_pop  in  1  D consumes head entry this cycle (D not stalled)
- D_flush  in  1  redirect: discard wrong-path entries
- D_keep_slot  in  1  with D_flush: retain one delay-slot instruction
- D_valid  out  1  head entry valid
- D_PC  out  32  head PC (0 when empty)
- D_Instr  out  32  head instruction (32'h0000_0000 = nop when empty)
- D_Imm  out  16  D_Instr[15:0], feeds the D-stage immediate extender
- count  out  log2(DEPTH)+1  occupancy

## Operation
- Circular buffer with rd_ptr and wr_ptr of log2(DEPTH) bits each, wrapping modulo DEPTH, plus an explicit count register.
- Push when F_valid && F_ready. Pop when D_pop && D_valid. D_pop with the queue empty is ignored and has no effect.
- F_ready = (count < DEPTH) || D_pop. A push into a full queue is legal in the same cycle as a pop; count is unchanged.
- Head outputs are a combinational read at rd_ptr, gated by D_valid = (count != 0). When empty, D_Instr, D_PC and D_Imm are all zero.
- Flush (D_flush=1) takes priority over a normal push in the same cycle. The pop in that cycle still retires the head.
  - With D_keep_slot=0: count←0, rd_ptr←wr_ptr, and the push of this cycle is dropped.
  - With D_keep_slot=1: the retained entry is the first entry not popped this cycle, if one exists. Otherwise it is the push of this cycle, if F_valid. Otherwise nothing is retained.
  - After a flush with a retained entry, the queue holds exactly that one entry at the new head (count=1). Every other entry is discarded.
- No state machine beyond the pointers and count. The design is a single always block on posedge clk / negedge reset_n for state, plus combinational next-state logic.

## Timing
- Reset values: rd_ptr=0, wr_ptr=0, count=0, D_valid=0, D_Instr=0, D_PC=0, D_Imm=0, F_ready=1. Reset is asynchronous and clears state immediately, even mid-operation; entry contents need not be cleared.
- Latency: an entry pushed in cycle N is visible on D_* in cycle N+1 at the earliest. There is no combinational F→D bypass.
- Throughput: one push and one pop per cycle sustained at any occupancy.
- A flush in cycle N: the retained delay slot, or empty, is visible in cycle N+1. F_Instr pushed in N+1 is the new-path instruction.
- Boundary behaviour:
  - Full with no pop: F_ready=0 and F must hold its inputs.
  - Empty with a push: D_valid rises the next cycle.
  - A pointer wrap from DEPTH-1 to 0 is transparent to D.

## Structure
- Shared package (cpu_defs): NOP_INSTR=32'h0000_0000, PC_WIDTH=32, INSTR_WIDTH=32, IMM_WIDTH=16.
- Natural sub-module: ifq_mem, a DEPTH×64 register array with one write port and two combinational read ports (head, head+1). The second read port is needed to select the delay slot on a flush with pop.
- Top level contains the pointer/count logic, flush selection and output gating.

## Test plan
- Reset then idle: every output is at its reset value and F_ready=1; D_pop with the queue empty leaves count=0.
- Push PC 0x3000..0x300C with D_pop=0 → count=4 and F_ready=0. Push 0x3010 while full → rejected. D_Instr shows the 0x3000 instruction and D_Imm equals its [15:0].
- Full queue, push 0x3010 plus pop in the same cycle → count stays 4; the head becomes 0x3004; after further pops, 0x3010 emerges in order across the pointer wrap.
- Queue holds 0x3000 (beq), 0x3004, 0x3008. Assert D_pop=1, D_flush=1, D_keep_slot=1 → next cycle count=1 with D_PC=0x3004; 0x3008 is gone.
- Queue holds only beq at 0x3000. Assert D_pop, D_flush and D_keep_slot with F pushing 0x3004 → next cycle count=1 and D_PC=0x3004. Repeat with D_keep_slot=0 → count=0 and D_valid=0.
- Deassert reset_n mid-stream with count=3 → outputs zero asynchronously; after release, the first push appears one cycle later at the head.
